// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: access sizes,
// FSM state encoding and the alignment rule used for fetch and data accesses.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP_I = 2'd1,
    ST_RESP_D = 2'd2
  } arb_state_e;

  // Fetches are checked as word accesses; size 3 is never a legal access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Core-side fetch and data buses of the memory arbiter.
// master = core (drives requests), slave = arbiter (drives grants/responses).
interface riscv_mem_arbiter_if;

  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        i_err_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [1:0]  d_size_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;

  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_size_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o
  );

  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_size_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o
  );

endinterface

// File: rtl/riscv_mem_arb_prio.sv
// Grant selection between fetch and data requesters. Default: data priority
// with a fetch starvation limit; RISCV_MEM_ARB_RR_EN selects round-robin.
module riscv_mem_arb_prio #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_fetch_req,
  input  logic i_data_req,
  output logic o_fetch_gnt,
  output logic o_data_gnt
);

  logic w_fetch_wins;

  // Grants are forced low while reset is held so nothing is accepted in reset.
  assign o_fetch_gnt = reset_i & w_fetch_wins;
  assign o_data_gnt  = reset_i & i_data_req & ~w_fetch_wins;

`ifdef RISCV_MEM_ARB_RR_EN

  logic r_last_data;

  assign w_fetch_wins = i_fetch_req & (~i_data_req | r_last_data);

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_last_data <= 1'b0;
    end else if (o_fetch_gnt || o_data_gnt) begin
      r_last_data <= o_data_gnt;
    end
  end

`else

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;

  assign w_fetch_wins = i_fetch_req & (~i_data_req | (r_starve_cnt == STARVE_LIM));

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_starve_cnt <= '0;
    end else if (!i_fetch_req || o_fetch_gnt) begin
      r_starve_cnt <= '0;
    end else if (o_data_gnt && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter for a RISC-V core's fetch and data buses; one
// access per cycle, response one cycle after grant. Option: RISCV_MEM_ARB_RR_EN.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  riscv_mem_arbiter_if.slave   bus,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [1:0]           mem_size_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  input  logic [31:0]          mem_rdata_i
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic       r_load;
  logic       w_load_nxt;

  logic       w_i_gnt;
  logic       w_d_gnt;
  logic       w_i_mis;
  logic       w_d_mis;

  riscv_mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .i_fetch_req (bus.i_req_i),
    .i_data_req  (bus.d_req_i),
    .o_fetch_gnt (w_i_gnt),
    .o_data_gnt  (w_d_gnt)
  );

  assign w_i_mis = is_misaligned(SIZE_WORD, bus.i_addr_i[1:0]);
  assign w_d_mis = is_misaligned(bus.d_size_i, bus.d_addr_i[1:0]);

  assign bus.i_gnt_o = w_i_gnt;
  assign bus.d_gnt_o = w_d_gnt;

  // r_load marks a data response whose rdata comes from memory (aligned load).
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      r_load  <= w_load_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_nxt    = ST_IDLE;
    w_err_nxt      = 1'b0;
    w_load_nxt     = 1'b0;
    mem_rd_o       = 1'b0;
    mem_wr_o       = 1'b0;
    mem_addr_o     = '0;
    mem_size_o     = '0;
    mem_wdata_o    = '0;
    bus.i_rvalid_o = 1'b0;
    bus.i_err_o    = 1'b0;
    bus.i_rdata_o  = '0;
    bus.d_rvalid_o = 1'b0;
    bus.d_err_o    = 1'b0;
    bus.d_rdata_o  = '0;

    // Misaligned grants still advance the FSM but never strobe memory.
    if (w_i_gnt) begin
      w_state_nxt = ST_RESP_I;
      w_err_nxt   = w_i_mis;
      if (!w_i_mis) begin
        mem_rd_o   = 1'b1;
        mem_addr_o = bus.i_addr_i;
        mem_size_o = SIZE_WORD;
      end
    end else if (w_d_gnt) begin
      w_state_nxt = ST_RESP_D;
      w_err_nxt   = w_d_mis;
      w_load_nxt  = ~bus.d_we_i & ~w_d_mis;
      if (!w_d_mis) begin
        mem_addr_o = bus.d_addr_i;
        mem_size_o = bus.d_size_i;
        if (bus.d_we_i) begin
          mem_wr_o    = 1'b1;
          mem_wdata_o = bus.d_wdata_i;
        end else begin
          mem_rd_o = 1'b1;
        end
      end
    end

    case (r_state)
      ST_RESP_I: begin
        bus.i_rvalid_o = 1'b1;
        bus.i_err_o    = r_err;
        bus.i_rdata_o  = r_err ? 32'h0 : mem_rdata_i;
      end
      ST_RESP_D: begin
        bus.d_rvalid_o = 1'b1;
        bus.d_err_o    = r_err;
        bus.d_rdata_o  = r_load ? mem_rdata_i : 32'h0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum number of consecutive data grants while a fetch request waits; range 1..15.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset_i  in  1  reset, asynchronous, active-low.
REQ-004 i_req_i  in  1  fetch request, held until granted.
REQ-005 i_addr_i  in  32  fetch byte address.
REQ-006 i_gnt_o  out  1  fetch request accepted this cycle.
REQ-007 i_rvalid_o  out  1  fetch response valid.
REQ-008 i_rdata_o  out  32  fetch instruction word.
REQ-009 i_err_o  out  1  fetch misaligned, valid with i_rvalid_o.
REQ-010 d_req_i  in  1  data request, held until granted.
REQ-011 d_we_i  in  1  1 = store, 0 = load.
REQ-012 d_addr_i  in  32  data byte address.
REQ-013 d_wdata_i  in  32  store data.
REQ-014 d_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-015 d_gnt_o  out  1  data request accepted this cycle.
REQ-016 d_rvalid_o  out  1  data response valid; pulses for loads and stores.
REQ-017 d_rdata_o  out  32  load data; 0 for stores and errors.
REQ-018 d_err_o  out  1  data misaligned or illegal size, valid with d_rvalid_o.
REQ-019 mem_addr_o/mem_wdata_o (32), mem_size_o (2), mem_rd_o/mem_wr_o (1)  out  single memory port; mem_rdata_i  in  32, valid one cycle after mem_rd_o.

Function
REQ-020 The arbiter SHALL grant at most one requester per cycle, and gnt SHALL be combinational from req and the registered state.
REQ-021 In the grant cycle G, the arbiter SHALL drive mem_addr_o, mem_size_o, and mem_rd_o or mem_wr_o; fetches SHALL use size 2 (word).
REQ-022 At G+1, the arbiter SHALL assert the owner's rvalid for exactly one cycle, with rdata = mem_rdata_i for reads.
REQ-023 FSM states SHALL be IDLE, RESP_I and RESP_D: a grant moves the FSM to RESP_x; RESP_x with a new grant moves to the new RESP_y; RESP_x with no grant moves to IDLE.
REQ-024 A new grant SHALL be allowed in a RESP cycle, giving back-to-back throughput of one access per cycle.
REQ-025 Priority SHALL be data over fetch, except that when the starvation counter equals STARVE_MAX and i_req_i is high, fetch SHALL win.
REQ-026 The starvation counter SHALL increment on each data grant while i_req_i=1, clear on a fetch grant or when i_req_i=0, and saturate at STARVE_MAX.
REQ-027 A misaligned access SHALL be granted without any memory strobe, and the arbiter SHALL give an error response at G+1 with rdata = 0. Misaligned means: half with addr[0]=1, word with addr[1:0]≠0, size 3, or a fetch with addr[1:0]≠0.
REQ-028 mem_wdata_o SHALL equal d_wdata_i when mem_wr_o=1 and 0 otherwise; address and size SHALL be 0 when no strobe is asserted.

Reset
REQ-029 While reset_i=0: state = IDLE, counter = 0, and all outputs = 0 (gnt, rvalid, err, rdata, strobes, address, size, wdata).
REQ-030 Reset asserted mid-transaction SHALL discard the pending response; no rvalid SHALL be issued after deassertion for a pre-reset grant.

Configuration
REQ-031 With RISCV_MEM_ARB_RR_EN defined, priority SHALL be round-robin: the last-granted requester loses ties, the starvation counter is removed, and STARVE_MAX is ignored.
REQ-032 Without RISCV_MEM_ARB_RR_EN defined, the arbiter SHALL use fixed data priority with the starvation limit of REQ-025/026.

Structure
REQ-033 Package riscv_mem_pkg SHALL hold the SIZE_BYTE/SIZE_HALF/SIZE_WORD constants, the FSM state enumeration and a misalignment-check function.
REQ-034 The priority/counter logic SHALL live in sub-module riscv_mem_arb_prio; the FSM and datapath muxing SHALL live in the top level.

Verification
REQ-035 Reset release, only i_req_i=1 at 0x4 with mem returning 0x00500093 -> i_gnt_o at G, i_rvalid_o=1 and i_rdata_o=0x00500093 at G+1, d_* outputs all 0.
REQ-036 d_req_i (load word, 0x100) and i_req_i asserted simultaneously -> d_gnt_o first; fetch granted next cycle; both responses on consecutive cycles.
REQ-037 Fixed mode, STARVE_MAX=4, continuous d_req_i and i_req_i -> 4 data grants, then 1 fetch grant, repeating.
REQ-038 Store half to 0x103 -> d_gnt_o=1, no mem_wr_o, d_rvalid_o=d_err_o=1 at G+1, d_rdata_o=0.
REQ-039 reset_i driven low in RESP_D after a load grant, released 2 cycles later -> no d_rvalid_o; first new request behaves as after reset.
REQ-040 RISCV_MEM_ARB_RR_EN defined, both requests held continuously -> grants alternate D, I, D, I.
